// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC generation, credit-limited in-order imem requests, response queue to decode, redirect flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_queue_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [`INSTR_LEN-1:0]  imem_rsp_data,
  output logic                   if_valid,
  output logic [`INSTR_LEN-1:0]  if_instr,
  output logic [ADDR_W-1:0]      if_pc,
  input  logic                   id_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_dropped,
  output logic [31:0]            perf_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [CW-1:0]         count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [`INSTR_LEN-1:0] q_instr_q [DEPTH];
  logic [ADDR_W-1:0]     q_pc_q    [DEPTH];
  logic [ADDR_W-1:0]     tag_q     [DEPTH];
  logic                  credit_s, req_fire_s, push_s, pop_s, unused_s;

  assign unused_s       = ^redirect_pc[1:0];
  assign credit_s       = ({1'b0, count_q} + {1'b0, out_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = rst_n & ~redirect_valid & credit_s;
  assign imem_addr      = pc_q;
  assign req_fire_s     = imem_req_valid & imem_req_ready;
  // A response is only kept when no stale responses remain to be dropped and no redirect flushes it.
  assign push_s         = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
  assign if_valid       = (count_q != '0);
  assign pop_s          = if_valid & id_ready & ~redirect_valid;
  assign if_instr       = if_valid ? q_instr_q[rd_ptr_q] : '0;
  assign if_pc          = if_valid ? q_pc_q[rd_ptr_q] : '0;

  // Next-state for PC, queue pointers and the outstanding/drop counters.
  always_comb begin
    out_d    = out_q + CW'(req_fire_s) - CW'(imem_rsp_valid);
    tag_wr_d = tag_wr_q + PW'(req_fire_s);
    tag_rd_d = tag_rd_q + PW'(imem_rsp_valid);
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      drop_d   = out_d;
    end else begin
      pc_d     = req_fire_s ? pc_q + ADDR_W'(4) : pc_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d = wr_ptr_q + PW'(push_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      drop_d   = (imem_rsp_valid && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  // Storage: request PC tags in issue order, and the instruction queue; outputs are gated by if_valid.
  always_ff @(posedge clk) begin
    if (req_fire_s) begin
      tag_q[tag_wr_q] <= pc_q;
    end
    if (push_s) begin
      q_instr_q[wr_ptr_q] <= imem_rsp_data;
      q_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_dropped <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(pop_s));
      perf_dropped <= sat_add(perf_dropped, 32'(imem_rsp_valid & ~push_s) +
                              (redirect_valid ? 32'(count_q) : 32'd0));
      perf_stall   <= sat_add(perf_stall, 32'(if_valid & ~id_ready));
    end
  end
`endif

  fetch_queue_unit_chk #(.CW(CW), .DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .count (count_q)
  );

endmodule

module fetch_queue_unit_chk #(
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic [CW-1:0] count
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == CW'(DEPTH))));
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized bench for fetch_queue_unit: epoch-tagged memory/queue reference model checked every cycle.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_fetch_queue_unit;
  localparam int          AW     = 64;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  imem_req_valid, imem_req_ready;
  logic [AW-1:0]         imem_addr;
  logic                  imem_rsp_valid;
  logic [`INSTR_LEN-1:0] imem_rsp_data;
  logic                  if_valid;
  logic [`INSTR_LEN-1:0] if_instr;
  logic [AW-1:0]         if_pc;
  logic                  id_ready, redirect_valid;
  logic [AW-1:0]         redirect_pc;

  fetch_queue_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [63:0] addr; int ep; int due; } req_t;

  ent_t        mq[$];
  req_t        mem[$];
  logic [63:0] m_pc;
  int          epoch, cyc;
  int          n_cmp, n_bad;
  logic        exp_req;
  int          p_rdy, p_idr, p_red, p_rsp, lat_max;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    imem_req_ready = ($urandom_range(99) < p_rdy);
    id_ready       = ($urandom_range(99) < p_idr);
    redirect_valid = ($urandom_range(999) < p_red);
    redirect_pc    = ($urandom_range(1) == 0) ? 64'($urandom_range(65535)) : {$urandom(), $urandom()};
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (mem.size() != 0) begin
      if (mem[0].due <= cyc && $urandom_range(99) < p_rsp) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem[0].addr);
      end
    end
  endtask

  task automatic compare();
    exp_req = !redirect_valid && ((mq.size() + mem.size()) < DEPTH);
    check_eq("req_valid", imem_req_valid, exp_req);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", if_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("if_pc", if_pc, mq[0].pc);
      check_eq("if_instr", if_instr, mq[0].ins);
    end
  endtask

  task automatic update();
    req_t r;
    logic got_rsp;
    cyc++;
    got_rsp = imem_rsp_valid;
    r = '{64'h0, -1, 0};
    if (got_rsp) r = mem.pop_front();
    if (redirect_valid) begin
      mq.delete();
      epoch++;
      m_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (got_rsp && r.ep == epoch) mq.push_back('{r.addr, instr_of(r.addr)});
      if (exp_req && imem_req_ready) begin
        mem.push_back('{m_pc, epoch, cyc + int'($urandom_range(lat_max - 1))});
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic run_phase(input int n, input int rdy, input int idr, input int red,
                           input int rsp, input int lat);
    p_rdy = rdy; p_idr = idr; p_red = red; p_rsp = rsp; lat_max = lat;
    for (int i = 0; i < n; i++) begin
      #1;
      drive();
      @(negedge clk);
      compare();
      @(posedge clk);
      update();
    end
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 64'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, imem_req_valid, 1'b0);
    check_eq({tag, "_if_valid"}, if_valid, 1'b0);
    check_eq({tag, "_if_instr"}, if_instr, 32'h0);
    check_eq({tag, "_if_pc"}, if_pc, 64'h0);
  endtask

  task automatic model_reset();
    mq.delete();
    mem.delete();
    m_pc = RST_PC;
    epoch++;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; epoch = 0;
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    check_reset_outputs("reset");
    check_eq("reset_addr", imem_addr, RST_PC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    run_phase(40, 100, 100, 0, 100, 1);     // streaming, latency 1
    run_phase(20, 100, 0, 0, 100, 1);       // decode stalled: queue fills, requests stop
    run_phase(20, 100, 100, 0, 100, 1);     // drain and resume
    run_phase(300, 100, 100, 80, 100, 3);   // latency 3 with redirects

    // Asynchronous reset between edges while traffic is in flight.
    run_phase(15, 100, 50, 0, 100, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    run_phase(10, 100, 100, 0, 100, 1);

    run_phase(2000, 70, 60, 50, 70, 4);     // mixed random traffic
    run_phase(500, 90, 90, 200, 90, 2);     // frequent back-to-back redirects

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
